// File: rtl/pl_muldiv_pkg.sv
// Shared types, constants and sign helpers for the iterative multiply/divide unit.
package pl_muldiv_pkg;

  localparam int unsigned MD_DATA_W = 32;
  localparam int unsigned MD_ITER   = MD_DATA_W;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } muldiv_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } md_state_t;

  function automatic logic [MD_DATA_W-1:0] md_neg(input logic [MD_DATA_W-1:0] v);
    return (~v) + MD_DATA_W'(1);
  endfunction

  // Magnitude of a two's-complement value; the most negative value maps onto itself.
  function automatic logic [MD_DATA_W-1:0] md_abs(input logic [MD_DATA_W-1:0] v);
    return v[MD_DATA_W-1] ? md_neg(v) : v;
  endfunction

endpackage

// File: rtl/pl_muldiv_unit.sv
// EX-stage iterative multiply/divide unit holding HI/LO: one shift-add or
// restoring shift-subtract step per cycle, then a sign-fix cycle.
module pl_muldiv_unit
  import pl_muldiv_pkg::*;
#(
  parameter int unsigned DATA_W = MD_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              start,
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] rs_data,
  input  logic [DATA_W-1:0] rt_data,
  output logic              busy,
  output logic              done,
  output logic              div_by_zero,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);

  localparam int unsigned ACC_W = 2 * DATA_W;
  localparam int unsigned SUM_W = DATA_W + 2;
  localparam int unsigned CNT_W = $clog2(DATA_W);

  md_state_t          state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [DATA_W-1:0]  b_q, b_d;
  logic [DATA_W-1:0]  rs_raw_q, rs_raw_d;
  logic               is_div_q, is_div_d;
  logic               neg_q, neg_d;
  logic               rem_neg_q, rem_neg_d;
  logic               zdiv_q, zdiv_d;
  logic [DATA_W-1:0]  hi_q, hi_d;
  logic [DATA_W-1:0]  lo_q, lo_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               dz_q, dz_d;

  logic [DATA_W:0]    opa_c;
  logic [DATA_W:0]    addend_c;
  logic [SUM_W-1:0]   sum_c;
  logic [ACC_W-1:0]   prod_c;
  logic               op_signed_c;
  logic               op_div_c;

  // Shared 33-bit adder: add for multiply, subtract (with carry-out = no borrow) for divide.
  always_comb begin
    opa_c    = is_div_q ? acc_q[ACC_W-1:DATA_W-1] : {1'b0, acc_q[ACC_W-1:DATA_W]};
    addend_c = is_div_q ? ~{1'b0, b_q} : {1'b0, b_q};
    sum_c    = {1'b0, opa_c} + {1'b0, addend_c} + SUM_W'(is_div_q);
    prod_c   = neg_q ? ((~acc_q) + ACC_W'(1)) : acc_q;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    b_d         = b_q;
    rs_raw_d    = rs_raw_q;
    is_div_d    = is_div_q;
    neg_d       = neg_q;
    rem_neg_d   = rem_neg_q;
    zdiv_d      = zdiv_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    done_d      = 1'b0;
    dz_d        = 1'b0;
    op_signed_c = (op == OP_MULT) || (op == OP_DIV);
    op_div_c    = (op == OP_DIV) || (op == OP_DIVU);

    case (state_q)
      IDLE: begin
        if (enable && start) begin
          case (op)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
              acc_d     = {{DATA_W{1'b0}}, (op_signed_c ? md_abs(rs_data) : rs_data)};
              b_d       = op_signed_c ? md_abs(rt_data) : rt_data;
              rs_raw_d  = rs_data;
              is_div_d  = op_div_c;
              neg_d     = op_signed_c && (rs_data[DATA_W-1] ^ rt_data[DATA_W-1]);
              rem_neg_d = (op == OP_DIV) && rs_data[DATA_W-1];
              zdiv_d    = op_div_c && (rt_data == '0);
              cnt_d     = '0;
              state_d   = RUN;
            end
            OP_MTHI: hi_d = rs_data;
            OP_MTLO: lo_d = rs_data;
            default: ;
          endcase
        end
      end
      RUN: begin
        if (is_div_q) begin
          acc_d = sum_c[SUM_W-1] ? {sum_c[DATA_W-1:0], acc_q[DATA_W-2:0], 1'b1}
                                 : {acc_q[ACC_W-2:0], 1'b0};
        end else begin
          acc_d = acc_q[0] ? {sum_c[DATA_W:0], acc_q[DATA_W-1:1]}
                           : {1'b0, acc_q[ACC_W-1:1]};
        end
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(DATA_W - 1)) state_d = FIX;
      end
      FIX: begin
        if (!is_div_q) begin
          hi_d = prod_c[ACC_W-1:DATA_W];
          lo_d = prod_c[DATA_W-1:0];
        end else if (zdiv_q) begin
          hi_d = rs_raw_q;
          lo_d = '1;
        end else begin
          hi_d = rem_neg_q ? md_neg(acc_q[ACC_W-1:DATA_W]) : acc_q[ACC_W-1:DATA_W];
          lo_d = neg_q ? md_neg(acc_q[DATA_W-1:0]) : acc_q[DATA_W-1:0];
        end
        done_d  = 1'b1;
        dz_d    = is_div_q && zdiv_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      b_q       <= '0;
      rs_raw_q  <= '0;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      zdiv_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dz_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      b_q       <= b_d;
      rs_raw_q  <= rs_raw_d;
      is_div_q  <= is_div_d;
      neg_q     <= neg_d;
      rem_neg_q <= rem_neg_d;
      zdiv_q    <= zdiv_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      dz_q      <= dz_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule

// File: tb/tb_pl_muldiv_unit.sv
// Scoreboard bench for pl_muldiv_unit: directed plan cases plus random ops
// checked against a plain-arithmetic reference model.
module tb_pl_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset, enable, start;
  logic [2:0]  op;
  logic [31:0] rs_data, rt_data;
  logic        busy, done, div_by_zero;
  logic [31:0] hi, lo;

  int n_pass  = 0;
  int n_total = 0;

  logic [64:0] sb_q[$];   // {div_by_zero, hi, lo}
  logic [31:0] mhi, mlo;

  pl_muldiv_unit dut (
    .clk(clk), .reset(reset), .enable(enable), .start(start), .op(op),
    .rs_data(rs_data), .rt_data(rt_data), .busy(busy), .done(done),
    .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Reference model from the architectural definition using 64-bit arithmetic.
  function automatic logic [64:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      3'd0: begin p = 64'(sa * sb); return {1'b0, p}; end
      3'd1: begin p = {32'd0, a} * {32'd0, b}; return {1'b0, p}; end
      3'd2: begin
        if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
        q = sa / sb;
        r = sa % sb;
        return {1'b0, 32'(r), 32'(q)};
      end
      3'd3: begin
        if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
        return {1'b0, a % b, a / b};
      end
      default: return {1'b0, mhi, mlo};
    endcase
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    logic [64:0] e;
    if (!reset) begin
      if (done) begin
        if (sb_q.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_done: got done=1 expected no pending result");
        end else begin
          e = sb_q.pop_front();
          check("result_hi", 64'(hi), 64'(e[63:32]));
          check("result_lo", 64'(lo), 64'(e[31:0]));
          check("result_dz", 64'(div_by_zero), 64'(e[64]));
        end
      end else if (div_by_zero) begin
        n_total++;
        $display("FAIL dz_without_done: got div_by_zero=1 expected 0");
      end
    end
  end

  // Drive one request for a single cycle; mul/div ops are followed to completion.
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [64:0] r;
    int cyc;
    @(negedge clk);
    enable = 1'b1; start = 1'b1; op = o; rs_data = a; rt_data = b;
    r = model(o, a, b);
    if (o <= 3'd3) begin
      sb_q.push_back(r);
      mhi = r[63:32]; mlo = r[31:0];
    end else if (o == 3'd4) mhi = a;
    else if (o == 3'd5) mlo = a;
    @(negedge clk);
    start = 1'b0; rs_data = $urandom; rt_data = $urandom; enable = 1'($urandom);
    if (o <= 3'd3) begin
      cyc = 0;
      while (busy && cyc < 100) begin
        cyc++;
        @(negedge clk);
      end
      check("busy_cycles", 64'(cyc), 64'd33);
      check("done_after_busy", 64'(done), 64'd1);
    end else begin
      check("busy_idle_op", 64'(busy), 64'd0);
      check("done_idle_op", 64'(done), 64'd0);
    end
    check("hi_after_op", 64'(hi), 64'(mhi));
    check("lo_after_op", 64'(lo), 64'(mlo));
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    mhi = '0; mlo = '0;
    sb_q.delete();
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    reset = 1'b1; enable = 1'b0; start = 1'b0; op = '0; rs_data = '0; rt_data = '0;
    mhi = '0; mlo = '0;
    repeat (2) @(negedge clk);
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_dz", 64'(div_by_zero), 64'd0);
    reset = 1'b0;

    issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("multu_max_hi", 64'(hi), 64'hFFFF_FFFE);
    check("multu_max_lo", 64'(lo), 64'h1);
    issue(3'd0, 32'hFFFF_FFFD, 32'd7);
    check("mult_neg_lo", 64'(lo), 64'hFFFF_FFEB);
    issue(3'd2, 32'hFFFF_FFF9, 32'd2);
    check("div_neg_lo", 64'(lo), 64'hFFFF_FFFD);
    check("div_neg_hi", 64'(hi), 64'hFFFF_FFFF);
    issue(3'd3, 32'd100, 32'd7);
    check("divu_lo", 64'(lo), 64'd14);
    check("divu_hi", 64'(hi), 64'd2);
    issue(3'd3, 32'd5, 32'd0);
    check("divu_zero_hi", 64'(hi), 64'd5);
    check("divu_zero_lo", 64'(lo), 64'hFFFF_FFFF);
    issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    check("div_ovf_lo", 64'(lo), 64'h8000_0000);
    check("div_ovf_hi", 64'(hi), 64'h0);
    issue(3'd4, 32'h0000_1234, 32'h0);
    check("mthi_hi", 64'(hi), 64'h1234);

    // MTLO arriving during RUN must be dropped.
    @(negedge clk);
    enable = 1'b1; start = 1'b1; op = 3'd1; rs_data = 32'd9; rt_data = 32'd9;
    sb_q.push_back({1'b0, 64'd81});
    @(negedge clk);
    op = 3'd5; rs_data = 32'hDEAD_BEEF;
    repeat (3) @(negedge clk);
    start = 1'b0;
    check("mtlo_in_run_lo", 64'(lo), 64'(mlo));
    mhi = 32'd0; mlo = 32'd81;
    for (int i = 0; i < 60 && busy; i++) @(negedge clk);
    check("mult_after_ignored_lo", 64'(lo), 64'd81);

    // Start with enable low is ignored.
    @(negedge clk);
    enable = 1'b0; start = 1'b1; op = 3'd4; rs_data = 32'hCAFE_0000;
    @(negedge clk);
    check("noen_mthi_hi", 64'(hi), 64'(mhi));
    op = 3'd0;
    @(negedge clk);
    check("noen_mult_busy", 64'(busy), 64'd0);
    start = 1'b0; enable = 1'b1;

    // Reset aborts an in-flight MULT.
    @(negedge clk);
    start = 1'b1; op = 3'd0; rs_data = 32'h1234_5678; rt_data = 32'h9ABC_DEF0;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    mhi = '0; mlo = '0;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_hi", 64'(hi), 64'd0);
    check("abort_lo", 64'(lo), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    issue(3'd1, 32'd2, 32'd3);
    check("post_abort_lo", 64'(lo), 64'd6);
    check("post_abort_hi", 64'(hi), 64'd0);

    for (int i = 0; i < 40; i++) begin
      issue(3'($urandom_range(0, 7)), pick_operand(), pick_operand());
    end

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pl_muldiv_unit.md
Name: pl_muldiv_unit

Overview:
- Iterative multiply/divide unit in the EX stage, directly downstream of the register-file read ports.
- Consumes rs/rt operand values (read_data_1/read_data_2 after forwarding) for MULT, MULTU, DIV, DIVU, MTHI and MTLO.
- Holds the architectural HI/LO registers and exposes them for MFHI/MFLO.
- Raises busy so the hazard unit can stall dependent instructions.

Parameters:
- DATA_W, 32, operand and HI/LO width. Iteration count equals DATA_W.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high; clears all state
- enable  input  1  pipeline advance; gates acceptance of start only
- start  input  1  request to execute op this cycle
- op  input  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; 6-7 ignored
- rs_data  input  DATA_W  operand A / dividend / MT source
- rt_data  input  DATA_W  operand B / divisor
- busy  output  1  iterative op in flight (registered)
- done  output  1  one-cycle pulse when HI/LO receive a mul/div result
- div_by_zero  output  1  one-cycle pulse alongside done when the divisor was 0
- hi  output  DATA_W  HI register
- lo  output  DATA_W  LO register

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (reset).
- Reset values: hi=0, lo=0, busy=0, done=0, div_by_zero=0, state=IDLE.
- Reset takes priority over everything, including an in-flight operation, which is aborted.
- Accept condition: enable && start && state==IDLE. Otherwise start is ignored, including while busy; no queueing.
- MTHI/MTLO accepted at edge E0: hi (or lo) <= rs_data at E0. No busy, no done.
- MUL/DIV accepted at edge E0:
  - Latch |rs| and |rt| (signed ops) or raw values (unsigned ops).
  - Latch the sign flags and the zero-divisor flag; counter=0; state IDLE->RUN.
- RUN state, edges E1..E32:
  - Multiply: one shift-add step per edge on a 64-bit accumulator.
  - Divide: one restoring shift-subtract step per edge.
  - At E32 (counter==DATA_W-1), state RUN->FIX.
- FIX state, edge E33:
  - Apply sign correction, write hi/lo, state->IDLE.
  - done=1 during the cycle after E33.
- busy = (state!=IDLE): high for exactly 33 cycles following E0, low in the cycle done is high.
- A new start is acceptable in the cycle after E33.
- Signed multiply: 64-bit product negated iff the operand signs differ; hi=product[63:32], lo=product[31:0].
- Signed divide:
  - Quotient negated iff signs differ; remainder takes the sign of the dividend.
  - lo=quotient, hi=remainder.
  - 0x80000000 / 0xFFFFFFFF yields lo=0x80000000, hi=0 (wraps; no trap).
- Divide by zero (DIV or DIVU):
  - Same 33-cycle latency; sign fix is bypassed.
  - hi=rs_data as latched, lo=0xFFFFFFFF.
  - div_by_zero pulses with done.
- Stalls: enable=0 does not pause an in-flight iteration. HI/LO still update at E33.
- hi/lo hold their old values while busy. Stalling MFHI/MFLO until busy==0 is the hazard unit's job.
- Operands are sampled only at E0. Later changes on rs_data/rt_data have no effect.

Decomposition:
- Shared package pl_muldiv_pkg:
  - muldiv_op_t enum (3-bit op codes above)
  - md_state_t enum {IDLE, RUN, FIX}
  - MD_ITER constant
  - abs/negate helper functions
- Single module; no sub-module needed. The datapath is one 64-bit shift register plus a 33-bit adder/subtractor shared between multiply and divide.

Test Plan:
- MULTU rs=0xFFFFFFFF, rt=0xFFFFFFFF -> busy high 33 cycles, then done pulse; hi=0xFFFFFFFE, lo=0x00000001.
- MULT rs=0xFFFFFFFD (-3), rt=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- DIV rs=0xFFFFFFF9 (-7), rt=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; then DIVU 100/7 -> lo=14, hi=2.
- DIVU rs=5, rt=0 -> hi=5, lo=0xFFFFFFFF, div_by_zero and done high together for one cycle. DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- MTHI rs=0x00001234 when idle -> hi=0x1234 next cycle, busy stays 0. MTLO with start during RUN -> ignored, lo unchanged. start with enable=0 -> ignored.
- MULT started, reset asserted at iteration 10 -> next cycle busy=0, hi=lo=0, no done. A MULTU 2*3 accepted right after reset completes normally with lo=6, hi=0.
